// File: rtl/wb_master_arbiter_n.sv
// N-master Wishbone classic arbiter and bus multiplexer.
// Masters compete on cyc. Arbitration is fixed-priority (index 0 wins) or
// round-robin. The grant is registered, and ownership is held for as long as
// the owner keeps cyc high. An optional per-transaction timeout returns err to
// a master whose strobe goes unanswered.
module wb_master_arbiter_n #(
  parameter int N_MASTERS = 3,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 24,
  parameter int SEL_W     = 2,
  parameter int RR_MODE   = 0,
  parameter int TIMEOUT   = 0,
  parameter int GNT_W     = $clog2(N_MASTERS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_MASTERS-1:0]        i_m_cyc,
  input  logic [N_MASTERS-1:0]        i_m_stb,
  input  logic [N_MASTERS-1:0]        i_m_we,
  input  logic [N_MASTERS*ADDR_W-1:0] i_m_adr,
  input  logic [N_MASTERS*DATA_W-1:0] i_m_dat,
  input  logic [N_MASTERS*SEL_W-1:0]  i_m_sel,
  output logic [N_MASTERS-1:0]        o_m_ack,
  output logic [N_MASTERS-1:0]        o_m_err,
  output logic [N_MASTERS-1:0]        o_m_rty,
  output logic                        wb_cyc,
  output logic                        wb_stb,
  output logic                        wb_we,
  output logic [ADDR_W-1:0]           wb_adr,
  output logic [DATA_W-1:0]           wb_o_dat,
  output logic [SEL_W-1:0]            wb_sel,
  input  logic                        wb_ack,
  input  logic                        wb_err,
  input  logic                        wb_rty,
  output logic [GNT_W-1:0]            o_grant,
  output logic                        o_grant_valid,
  output logic                        o_timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [GNT_W-1:0] grant_reg, grant_next;
  logic [GNT_W-1:0] ptr_reg, ptr_next;

  logic [GNT_W-1:0] win_idx;
  logic [GNT_W-1:0] win_ptr;
  logic             any_req;
  logic             grant_valid;
  logic             owner_cyc;
  logic             arb_point;
  logic             bus_resp;
  logic             tmo_fire;
  int               rr_cand;
  int               ptr_wrap;

  // Per-master slices unpacked into arrays so the mux can index them by grant.
  logic [ADDR_W-1:0] m_adr [N_MASTERS];
  logic [DATA_W-1:0] m_dat [N_MASTERS];
  logic [SEL_W-1:0]  m_sel [N_MASTERS];
  logic [N_MASTERS-1:0] grant_hit;

  generate
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_slice
      assign m_adr[gi] = i_m_adr[gi*ADDR_W +: ADDR_W];
      assign m_dat[gi] = i_m_dat[gi*DATA_W +: DATA_W];
      assign m_sel[gi] = i_m_sel[gi*SEL_W +: SEL_W];
    end
  endgenerate

  assign grant_valid = (state_reg == ST_OWNED);
  assign owner_cyc   = i_m_cyc[grant_reg];
  assign any_req     = |i_m_cyc;
  assign bus_resp    = wb_ack | wb_err | wb_rty;

  // A new owner may be picked only when the bus is free or the owner released cyc.
  assign arb_point = (state_reg == ST_IDLE) | ~owner_cyc;

  // Winner search. Scanning from the far end down lets the nearest candidate
  // overwrite the others, so no early exit is needed.
  always_comb begin
    win_idx = '0;
    rr_cand = 0;
    if (RR_MODE != 0) begin
      for (int off = N_MASTERS - 1; off >= 0; off--) begin
        rr_cand = int'(ptr_reg) + off;
        if (rr_cand >= N_MASTERS) begin
          rr_cand = rr_cand - N_MASTERS;
        end
        if (i_m_cyc[GNT_W'(rr_cand)]) begin
          win_idx = GNT_W'(rr_cand);
        end
      end
    end else begin
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        if (i_m_cyc[GNT_W'(i)]) begin
          win_idx = GNT_W'(i);
        end
      end
    end
  end

  // Round-robin pointer that follows a new grant: one past the winner, wrapping.
  always_comb begin
    ptr_wrap = int'(win_idx) + 1;
    if (ptr_wrap >= N_MASTERS) begin
      ptr_wrap = 0;
    end
    win_ptr = GNT_W'(ptr_wrap);
  end

  // Next-state logic: hand off directly to a waiting requester, else go idle.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    if (arb_point) begin
      if (any_req) begin
        state_next = ST_OWNED;
        grant_next = win_idx;
        ptr_next   = win_ptr;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  // Ownership registers. Reset drops any owner at once, even mid-transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Bus side multiplexer. It is driven from the registered grant and forced
  // to zero while there is no owner.
  assign wb_cyc   = grant_valid & owner_cyc;
  assign wb_stb   = wb_cyc & i_m_stb[grant_reg];
  assign wb_we    = grant_valid & i_m_we[grant_reg];
  assign wb_adr   = grant_valid ? m_adr[grant_reg] : '0;
  assign wb_o_dat = grant_valid ? m_dat[grant_reg] : '0;
  assign wb_sel   = grant_valid ? m_sel[grant_reg] : '0;

  // Responses go only to the owner. A timeout is reported as err.
  generate
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_resp
      assign grant_hit[gi] = grant_valid & (grant_reg == GNT_W'(gi));
      assign o_m_ack[gi]   = grant_hit[gi] & wb_ack;
      assign o_m_err[gi]   = grant_hit[gi] & (wb_err | tmo_fire);
      assign o_m_rty[gi]   = grant_hit[gi] & wb_rty;
    end
  endgenerate

  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      logic [CNT_W-1:0] tmo_cnt_reg;

      // A real response on the final cycle takes precedence over the timeout.
      assign tmo_fire = wb_stb & ~bus_resp & (tmo_cnt_reg == CNT_W'(TIMEOUT - 1));

      // Counts unanswered strobe cycles. It restarts on a response, an idle
      // strobe, an owner change or a fired timeout.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          tmo_cnt_reg <= '0;
        end else if (~wb_stb | bus_resp | tmo_fire | arb_point) begin
          tmo_cnt_reg <= '0;
        end else begin
          tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
        end
      end
    end else begin : g_no_tmo
      assign tmo_fire = 1'b0;
    end
  endgenerate

  assign o_timeout     = tmo_fire;
  assign o_grant       = grant_reg;
  assign o_grant_valid = grant_valid;

endmodule

// File: doc/wb_master_arbiter_n.md
Name: wb_master_arbiter_n

Overview:
- N-master Wishbone classic arbiter plus bus multiplexer; generalised successor of the core's 2-master priority arbiter and its hand-written mux.
- Sits between the core's master adapters (icache, data adapter, future DMA/debug masters) and the single external Wishbone bus.
- Adds selectable fixed-priority or round-robin arbitration, direct grant handoff, and a per-transaction bus timeout that returns err to the stalled master.

Parameters:
- N_MASTERS, 3, number of masters, 2..8; index 0 is highest priority in fixed mode.
- DATA_W, 16, Wishbone data width.
- ADDR_W, 24, Wishbone address width.
- SEL_W, 2, byte-select width.
- RR_MODE, 0, 0 = fixed priority, 1 = round-robin.
- TIMEOUT, 0, cycles of unanswered stb before a forced err; 0 disables the timeout.
- GNT_W, $clog2(N_MASTERS), width of the grant index (derived).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_m_cyc  in  N_MASTERS  per-master cyc.
- i_m_stb  in  N_MASTERS  per-master stb.
- i_m_we  in  N_MASTERS  per-master we.
- i_m_adr  in  N_MASTERS*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W].
- i_m_dat  in  N_MASTERS*DATA_W  packed write data.
- i_m_sel  in  N_MASTERS*SEL_W  packed byte selects.
- o_m_ack  out  N_MASTERS  per-master ack.
- o_m_err  out  N_MASTERS  per-master err.
- o_m_rty  out  N_MASTERS  per-master rty.
- wb_cyc, wb_stb, wb_we  out  1 each  bus side.
- wb_adr  out  ADDR_W  bus address.
- wb_o_dat  out  DATA_W  bus write data.
- wb_sel  out  SEL_W  bus byte select.
- wb_ack, wb_err, wb_rty  in  1 each  bus responses.
- o_grant  out  GNT_W  index of the current owner.
- o_grant_valid  out  1  an owner exists.
- o_timeout  out  1  one-cycle pulse when a timeout fires.

Read data (wb_i_dat) is broadcast to all masters outside this block.

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous and active-high.
- Reset: grant_valid=0, grant=0, RR pointer=0, timeout counter=0. On the cycle after the reset edge:
  - all wb_* outputs are 0;
  - all o_m_* outputs are 0;
  - o_timeout=0.
  - A reset asserted mid-transaction drops ownership immediately, with no ack passed through.
- States: IDLE (grant_valid=0) and OWNED (grant_valid=1).
- Arbitration is evaluated when either:
  - the block is in IDLE, or
  - it is in OWNED and i_m_cyc[grant]==0.

  Winner selection:
  - Fixed mode: lowest-index requesting master wins.
  - Round-robin mode: the first requester searching from ptr upward, wrapping modulo N_MASTERS.
- Grant is registered, so latency is 1 cycle from cyc to wb_cyc.
- If requests exist at an arbitration point, the next state is OWNED with the new grant (direct handoff, no idle cycle). Otherwise the next state is IDLE.
- RR pointer update: on each new grant, ptr <= winner+1, wrapping to 0 at N_MASTERS.
- Ownership is never preempted while i_m_cyc[grant]==1; this also covers RMW and burst cycles.
- Mux (combinational from the registered grant):
  - wb_cyc = grant_valid & i_m_cyc[grant];
  - wb_stb = wb_cyc & i_m_stb[grant];
  - we, adr, dat and sel come from the granted slice.
- Response routing:
  - o_m_ack/err/rty[grant] = wb_ack/err/rty, gated by grant_valid.
  - All other masters' responses are 0.
- Timeout (TIMEOUT>0):
  - Counter behaviour:
    - increments each cycle wb_stb=1 and wb_ack|wb_err|wb_rty=0;
    - clears on any response, on wb_stb=0, or on a grant change.
  - When the counter == TIMEOUT-1 and still no response:
    - o_m_err[grant]=1 for that cycle;
    - o_timeout=1 for that cycle;
    - the counter clears.
  - A real response arriving on the same cycle takes precedence; no timeout fires.
- Simultaneous events: a master dropping cyc while others request means handoff the next cycle. A single requester re-raising cyc right after dropping it is re-granted after 1 IDLE cycle.

Test Plan:
- Reset: hold i_rst for 2 cycles with all i_m_cyc=1 -> wb_cyc=0 and o_grant_valid=0 throughout. On the first cycle after release, grant=0 and wb_cyc=1 (fixed mode).
- Fixed priority (RR_MODE=0, N=3): masters 1 and 2 request together -> grant=1. Master 0 raises cyc mid-cycle -> no preemption. When master 1 drops cyc, the next grant is 0, not 2.
- Round-robin (RR_MODE=1, N=3): all three request continuously, each holding for one ack and then dropping cyc -> grant sequence 0,1,2,0, with no IDLE cycles between owners.
- Mux/response: master 2 granted with adr=24'h00ABCD, dat=16'h1234, we=1, sel=2'b11 -> bus shows exactly these values. wb_ack is routed only to o_m_ack[2]; o_m_ack[0] and o_m_ack[1] stay 0.
- Timeout (TIMEOUT=4): granted master holds stb with no response -> o_m_err[grant] and o_timeout pulse on the 4th stb cycle. With ack on the 4th cycle instead -> ack only, no err.
- Reset mid-transaction: assert i_rst while master 1 is owned with stb high and wb_ack high that same cycle -> next cycle wb_cyc=0, all o_m_ack=0, RR ptr=0.
